// File: rtl/scalar_multiplication_pkg.sv
// Shared widths, controller/adder state encodings and test-curve constants
// for the double-and-add scalar multiplier.
package scalar_multiplication_pkg;

  localparam int N_DEF  = 10;
  localparam int KW_DEF = 10;

  localparam int CURVE_P     = 17;
  localparam int CURVE_A     = 2;
  localparam int CURVE_B     = 2;
  localparam int BASE_X      = 5;
  localparam int BASE_Y      = 1;
  localparam int CURVE_ORDER = 19;

  typedef enum logic [3:0] {
    IDLE,
    DBL,
    DBL_GO,
    DBL_WAIT,
    ADDCHK,
    ADD_GO,
    ADD_WAIT,
    NEXT,
    FIN
  } sm_state_t;

  typedef enum logic [2:0] {
    PA_INIT,
    PA_INV,
    PA_LAM,
    PA_X3,
    PA_Y3,
    PA_DONE
  } pa_state_t;

endpackage

// File: rtl/scalar_multiplication_point_addition.sv
// Affine point adder/doubler mod p; restarts whenever reset is high.
// Inverse found by stepping multiples of the denominator until one hits 1.
module point_addition
  import scalar_multiplication_pkg::*;
#(
  parameter int n = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);

  localparam logic [n-1:0] A_C = n'(CURVE_A);

  function automatic logic [n-1:0] mod_add(
    input logic [n-1:0] a,
    input logic [n-1:0] b,
    input logic [n-1:0] m
  );
    logic [n:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[n-1:0];
  endfunction

  function automatic logic [n-1:0] mod_sub(
    input logic [n-1:0] a,
    input logic [n-1:0] b,
    input logic [n-1:0] m
  );
    if (a >= b) return a - b;
    return a + m - b;
  endfunction

  function automatic logic [n-1:0] mod_mul(
    input logic [n-1:0] a,
    input logic [n-1:0] b,
    input logic [n-1:0] m
  );
    logic [2*n-1:0] pr;
    logic [2*n-1:0] r;
    pr = {{n{1'b0}}, a} * {{n{1'b0}}, b};
    r  = pr % {{n{1'b0}}, m};
    return r[n-1:0];
  endfunction

  pa_state_t    st;
  logic [n-1:0] num;
  logic [n-1:0] den;
  logic [n-1:0] prod;
  logic [n-1:0] t;
  logic [n-1:0] lam;

  logic         same;
  logic         opp;
  logic [n-1:0] sq;
  logic [n-1:0] i_num;
  logic [n-1:0] i_den;

  assign same  = (x1 == x2) && (y1 == y2);
  assign opp   = (x1 == x2) && (mod_add(y1, y2, p) == '0);
  assign sq    = mod_mul(x1, x1, p);
  assign i_num = same
    ? mod_add(mod_add(mod_add(sq, sq, p), sq, p), A_C, p)
    : mod_sub(y2, y1, p);
  assign i_den = same ? mod_add(y1, y1, p) : mod_sub(x2, x1, p);

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= PA_INIT;
      num      <= '0;
      den      <= '0;
      prod     <= '0;
      t        <= '0;
      lam      <= '0;
      x3       <= '0;
      y3       <= '0;
      result   <= 1'b0;
      infinity <= 1'b0;
    end else begin
      unique case (st)
        PA_INIT: begin
          if (opp) begin
            infinity <= 1'b1;
            st       <= PA_DONE;
          end else begin
            num  <= i_num;
            den  <= i_den;
            prod <= i_den;
            t    <= n'(1);
            st   <= PA_INV;
          end
        end
        PA_INV: begin
          if (prod == n'(1)) begin
            st <= PA_LAM;
          end else if (t >= p - n'(1)) begin
            infinity <= 1'b1;
            st       <= PA_DONE;
          end else begin
            prod <= mod_add(prod, den, p);
            t    <= t + n'(1);
          end
        end
        PA_LAM: begin
          lam <= mod_mul(num, t, p);
          st  <= PA_X3;
        end
        PA_X3: begin
          x3 <= mod_sub(mod_sub(mod_mul(lam, lam, p), x1, p), x2, p);
          st <= PA_Y3;
        end
        PA_Y3: begin
          y3     <= mod_sub(mod_mul(lam, mod_sub(x1, x3, p), p), y1, p);
          result <= 1'b1;
          st     <= PA_DONE;
        end
        PA_DONE: st <= PA_DONE;
        default: st <= PA_INIT;
      endcase
    end
  end

endmodule

// File: rtl/scalar_multiplication.sv
// Left-to-right double-and-add controller for R = k*P; infinity is a flag,
// never an adder operand. The adder is restarted by pulsing its reset.
module scalar_multiplication
  import scalar_multiplication_pkg::*;
#(
  parameter int n  = N_DEF,
  parameter int KW = KW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [n-1:0]  p,
  input  logic [KW-1:0] k,
  input  logic [n-1:0]  xp,
  input  logic [n-1:0]  yp,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  xr,
  output logic [n-1:0]  yr,
  output logic          infinity
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  sm_state_t     state;
  logic [KW-1:0] kreg;
  logic [n-1:0]  px;
  logic [n-1:0]  py;
  logic [n-1:0]  ax;
  logic [n-1:0]  ay;
  logic          acc_inf;
  logic [IW-1:0] idx;
  logic          seen;

  logic [n-1:0]  op_x1;
  logic [n-1:0]  op_y1;
  logic [n-1:0]  op_x2;
  logic [n-1:0]  op_y2;

  logic          add_go;
  logic          add_rst;
  logic [n-1:0]  a_x3;
  logic [n-1:0]  a_y3;
  logic          a_res;
  logic          a_inf;

  assign add_go  = (state == DBL_GO) || (state == ADD_GO);
  assign add_rst = reset | add_go;

  point_addition #(.n(n)) u_add (
    .clk     (clk),
    .reset   (add_rst),
    .p       (p),
    .x1      (op_x1),
    .y1      (op_y1),
    .x2      (op_x2),
    .y2      (op_y2),
    .x3      (a_x3),
    .y3      (a_y3),
    .result  (a_res),
    .infinity(a_inf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      kreg     <= '0;
      px       <= '0;
      py       <= '0;
      ax       <= '0;
      ay       <= '0;
      acc_inf  <= 1'b0;
      idx      <= '0;
      seen     <= 1'b0;
      op_x1    <= '0;
      op_y1    <= '0;
      op_x2    <= '0;
      op_y2    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      xr       <= '0;
      yr       <= '0;
      infinity <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            kreg    <= k;
            px      <= xp;
            py      <= yp;
            acc_inf <= 1'b1;
            idx     <= IW'(KW - 1);
            busy    <= 1'b1;
            state   <= DBL;
          end
        end
        DBL: begin
          if (acc_inf) begin
            state <= ADDCHK;
          end else begin
            op_x1 <= ax;
            op_y1 <= ay;
            op_x2 <= ax;
            op_y2 <= ay;
            state <= DBL_GO;
          end
        end
        DBL_GO, ADD_GO: begin
          seen  <= 1'b0;
          state <= (state == DBL_GO) ? DBL_WAIT : ADD_WAIT;
        end
        DBL_WAIT, ADD_WAIT: begin
          // Capture one cycle after the adder first flags completion.
          if (seen) begin
            ax      <= a_inf ? '0 : a_x3;
            ay      <= a_inf ? '0 : a_y3;
            acc_inf <= a_inf;
            state   <= (state == DBL_WAIT) ? ADDCHK : NEXT;
          end else if (a_res || a_inf) begin
            seen <= 1'b1;
          end
        end
        ADDCHK: begin
          if (!kreg[idx]) begin
            state <= NEXT;
          end else if (acc_inf) begin
            ax      <= px;
            ay      <= py;
            acc_inf <= 1'b0;
            state   <= NEXT;
          end else begin
            op_x1 <= ax;
            op_y1 <= ay;
            op_x2 <= px;
            op_y2 <= py;
            state <= ADD_GO;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= FIN;
          end else begin
            idx   <= idx - IW'(1);
            state <= DBL;
          end
        end
        FIN: begin
          xr       <= acc_inf ? '0 : ax;
          yr       <= acc_inf ? '0 : ay;
          infinity <= acc_inf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
